// File: rtl/uart_loader_pkg.sv
// Shared command codes, reply codes and state encodings for the serial bootloader.
package uart_loader_pkg;

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // addr_hi, addr_lo, data_hi, data_lo, chk
  localparam int ARG_BYTES = 5;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ARGS,
    P_CHECK,
    P_WRITE,
    P_REPLY
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_loader_tx.sv
// 8N1 byte serialiser for the bootloader reply; txd idles high.
module uart_loader_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_txd,
  output logic       o_tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             r_busy;
  logic             r_txd;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_cnt;
  logic [8:0]       r_shift;

  // r_shift holds the remaining data bits with the stop bit on top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_txd     <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy    <= 1'b1;
        r_txd     <= 1'b0;
        r_shift   <= {1'b1, i_byte};
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
      end
    end else if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
      r_clk_cnt <= '0;
      if (r_bit_cnt == 4'd9) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_txd     <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  assign o_txd     = r_txd;
  assign o_tx_busy = r_busy;

endmodule

// File: rtl/uart_loader.sv
// Serial bootloader: receives R/G/W command frames on rxd, writes program memory,
// holds the core in reset while loading and answers each frame with ACK/NAK on txd.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 14,
  parameter int TIMEOUT_BITS = 32,
  parameter bit BOOT_HELD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              txd,
  output logic              core_rst,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_data,
  output logic              pmem_wr_en,
  output logic              busy
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int GAP_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_LIM + 1);

  function automatic logic f_frame_ok(input logic [7:0] sum, input logic [7:0] addr_hi,
                                      input logic [7:0] data_hi, input logic core_held);
    return (sum == 8'h00) && ((addr_hi >> (ADDR_W - 8)) == 8'h00) &&
           ((data_hi >> (DATA_W - 8)) == 8'h00) && core_held;
  endfunction

  // RX synchroniser and receiver
  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bitn;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid;
  logic             r_rx_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bitn  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2 && r_rx_s3) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Mid-start re-check rejects short glitches
          if (r_rx_cnt == CNT_W'(HALF - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_bitn  <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bitn == 3'd7) r_rx_state <= RX_STOP;
            else                   r_rx_bitn  <= r_rx_bitn + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) r_rx_valid <= 1'b1;
            else         r_rx_ferr  <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Parser
  parser_state_t     r_state;
  logic              r_core_rst;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_pmem_addr;
  logic [DATA_W-1:0] r_pmem_data;
  logic              r_tx_start;
  logic [7:0]        r_tx_byte;
  logic [2:0]        r_arg_cnt;
  logic [7:0]        r_sum;
  logic [7:0]        r_args [0:3];
  logic [GAP_W-1:0]  r_gap;
  logic              w_tx_busy;
  logic              w_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= P_IDLE;
      r_core_rst  <= BOOT_HELD;
      r_wr_en     <= 1'b0;
      r_pmem_addr <= '0;
      r_pmem_data <= '0;
      r_tx_start  <= 1'b0;
      r_arg_cnt   <= '0;
      r_sum       <= '0;
      r_gap       <= '0;
    end else begin
      r_wr_en    <= 1'b0;
      r_tx_start <= 1'b0;

      // Idle time on the line since the last completed byte
      if (r_rx_state != RX_IDLE || r_rx_valid || r_rx_ferr) r_gap <= '0;
      else if (r_gap != GAP_W'(GAP_LIM))                    r_gap <= r_gap + 1'b1;

      case (r_state)
        P_IDLE: begin
          if (r_rx_ferr) begin
            r_state    <= P_REPLY;
            r_tx_start <= 1'b1;
            r_tx_byte  <= NAK_BYTE;
          end else if (r_rx_valid) begin
            if (r_rx_byte_is(CMD_W)) begin
              r_state   <= P_ARGS;
              r_sum     <= r_rx_shift;
              r_arg_cnt <= '0;
            end else begin
              r_state    <= P_REPLY;
              r_tx_start <= 1'b1;
              r_tx_byte  <= NAK_BYTE;
              if (r_rx_byte_is(CMD_R)) begin
                r_core_rst <= 1'b1;
                r_tx_byte  <= ACK_BYTE;
              end else if (r_rx_byte_is(CMD_G)) begin
                r_core_rst <= 1'b0;
                r_tx_byte  <= ACK_BYTE;
              end
            end
          end
        end
        P_ARGS: begin
          if (r_rx_ferr) begin
            r_state    <= P_REPLY;
            r_tx_start <= 1'b1;
            r_tx_byte  <= NAK_BYTE;
          end else if (r_rx_valid) begin
            r_sum <= r_sum + r_rx_shift;
            if (r_arg_cnt == 3'(ARG_BYTES - 1)) begin
              r_state     <= P_CHECK;
              r_pmem_addr <= {r_args[0][ADDR_W-9:0], r_args[1]};
              r_pmem_data <= {r_args[2][DATA_W-9:0], r_args[3]};
            end else begin
              r_args[r_arg_cnt[1:0]] <= r_rx_shift;
              r_arg_cnt              <= r_arg_cnt + 3'd1;
            end
          end else if (r_gap == GAP_W'(GAP_LIM)) begin
            r_state <= P_IDLE;
          end
        end
        P_CHECK: begin
          r_tx_start <= 1'b1;
          if (f_frame_ok(r_sum, r_args[0], r_args[2], r_core_rst)) begin
            r_state   <= P_WRITE;
            r_wr_en   <= 1'b1;
            r_tx_byte <= ACK_BYTE;
          end else begin
            r_state   <= P_REPLY;
            r_tx_byte <= NAK_BYTE;
          end
        end
        P_WRITE: r_state <= P_REPLY;
        P_REPLY: begin
          // Incoming bytes are ignored until the reply's stop bit is out
          if (!r_tx_start && !w_tx_busy) r_state <= P_IDLE;
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  function automatic logic r_rx_byte_is(input logic [7:0] code);
    return r_rx_shift == code;
  endfunction

  uart_loader_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (r_tx_start),
    .i_byte   (r_tx_byte),
    .o_txd    (w_txd),
    .o_tx_busy(w_tx_busy)
  );

  assign txd        = w_txd;
  assign core_rst   = r_core_rst;
  assign pmem_addr  = r_pmem_addr;
  assign pmem_data  = r_pmem_data;
  assign pmem_wr_en = r_wr_en;
  assign busy       = (r_state != P_IDLE) || w_tx_busy;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed and randomised frames checked against a frame-level model.
module tb_uart_loader;

  localparam int CPB = 4;
  localparam int TOB = 4;
  localparam int AW  = 11;
  localparam int DW  = 14;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          txd;
  logic          core_rst;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] pmem_data;
  logic          pmem_wr_en;
  logic          busy;

  always #5 clk = ~clk;

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_BITS(TOB),
    .BOOT_HELD   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .txd       (txd),
    .core_rst  (core_rst),
    .pmem_addr (pmem_addr),
    .pmem_data (pmem_data),
    .pmem_wr_en(pmem_wr_en),
    .busy      (busy)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;
  logic [8:0]    tx_q [$];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  bit            dec_active = 1'b0;
  bit            chk_next   = 1'b0;
  bit            exp_core   = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what reply, write and core_rst a complete frame produces
  function automatic void model(input logic [7:0] fr [0:5], input int n, input bit ferr,
                                input bit rst_in, output bit has_reply, output logic [7:0] reply,
                                output bit wr, output int addr, output int data, output bit rst_out);
    int sum;
    rst_out = rst_in; has_reply = 1'b1; reply = NAK; wr = 1'b0; addr = 0; data = 0;
    if (ferr) return;
    if (fr[0] == 8'h52) begin
      rst_out = 1'b1; reply = ACK;
    end else if (fr[0] == 8'h47) begin
      rst_out = 1'b0; reply = ACK;
    end else if (fr[0] == 8'h57) begin
      if (n < 6) begin
        has_reply = 1'b0;
      end else begin
        sum = 0;
        for (int i = 0; i < 6; i++) sum += int'(fr[i]);
        if ((sum % 256) == 0 && int'(fr[1]) < (1 << (AW - 8)) &&
            int'(fr[3]) < (1 << (DW - 8)) && rst_in) begin
          wr = 1'b1; reply = ACK;
          addr = int'(fr[1]) * 256 + int'(fr[2]);
          data = int'(fr[3]) * 256 + int'(fr[4]);
        end
      end
    end
  endfunction

  task automatic set_w(output logic [7:0] fr [0:5], input logic [7:0] ah, input logic [7:0] al,
                       input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] skew);
    fr[0] = 8'h57; fr[1] = ah; fr[2] = al; fr[3] = dh; fr[4] = dl;
    fr[5] = 8'h00 - (8'h57 + ah + al + dh + dl) + skew;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk); rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic flush();
    tx_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy && !dec_active) break;
    end
    check({tag, ".idle_in_time"}, 32'(k < 600), 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] fr [0:5], input int n, input bit stop_last, input string tag);
    bit has_reply, wr, rst_out;
    logic [7:0] reply;
    int addr, data;
    flush();
    for (int i = 0; i < n; i++) send_byte(fr[i], (i == n - 1) ? stop_last : 1'b1);
    wait_idle(tag);
    repeat (10) @(negedge clk);
    model(fr, n, !stop_last, exp_core, has_reply, reply, wr, addr, data, rst_out);
    check({tag, ".reply_count"}, tx_q.size(), has_reply ? 1 : 0);
    if (has_reply && tx_q.size() > 0) check({tag, ".reply_byte"}, tx_q[0], {1'b1, reply});
    check({tag, ".write_count"}, wa_q.size(), wr ? 1 : 0);
    if (wr && wa_q.size() > 0) begin
      check({tag, ".write_addr"}, wa_q[0], addr);
      check({tag, ".write_data"}, wd_q[0], data);
    end
    check({tag, ".core_rst"}, core_rst, rst_out);
    exp_core = rst_out;
  endtask

  // TX decoder: samples each bit near its middle and queues {stop, data}
  initial begin
    logic [8:0] v;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        dec_active = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (CPB) @(negedge clk);
          v[i] = txd;
        end
        tx_q.push_back(v);
        dec_active = 1'b0;
      end
    end
  end

  // Write monitor: records every strobe cycle and checks the reply starts right after it
  initial begin
    forever begin
      @(negedge clk);
      if (chk_next) begin
        check("tx_start_follows_strobe", 32'(txd), 32'd0);
        chk_next = 1'b0;
      end
      if (pmem_wr_en === 1'b1) begin
        wa_q.push_back(pmem_addr);
        wd_q.push_back(pmem_data);
        chk_next = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr [0:5];
    logic [7:0] ah, dh, ub;
    int kind;

    rst = 1'b1; rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset.txd", txd, 1);
    check("reset.core_rst", core_rst, 1);
    check("reset.wr_en", pmem_wr_en, 0);
    check("reset.addr", pmem_addr, 0);
    check("reset.data", pmem_data, 0);
    check("reset.busy", busy, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("idle.no_write", wa_q.size(), 0);
    check("idle.no_tx", tx_q.size(), 0);
    check("idle.txd", txd, 1);

    fr = '{8'h57, 8'h00, 8'h10, 8'h3F, 8'hFF, 8'h5B};
    run_txn(fr, 6, 1'b1, "w_valid");
    fr[5] = 8'h5C;
    run_txn(fr, 6, 1'b1, "w_badchk");

    fr = '{8'h47, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(fr, 1, 1'b1, "cmd_g");
    fr = '{8'h57, 8'h00, 8'h10, 8'h3F, 8'hFF, 8'h5B};
    run_txn(fr, 6, 1'b1, "w_core_running");
    fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(fr, 1, 1'b1, "cmd_r");

    fr = '{8'h57, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(fr, 2, 1'b1, "timeout");
    repeat (20 * CPB) @(negedge clk);
    check("timeout.busy_after", busy, 0);
    fr = '{8'h57, 8'h00, 8'h10, 8'h3F, 8'hFF, 8'h5B};
    run_txn(fr, 6, 1'b1, "w_after_timeout");
    set_w(fr, 8'h08, 8'h10, 8'h3F, 8'hFF, 8'h00);
    run_txn(fr, 6, 1'b1, "w_addr_hi_bad");
    set_w(fr, 8'h01, 8'h23, 8'h40, 8'h00, 8'h00);
    run_txn(fr, 6, 1'b1, "w_data_hi_bad");

    fr = '{8'h47, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(fr, 1, 1'b0, "ferr_stop0");

    flush();
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch.no_reply", tx_q.size(), 0);
    check("glitch.busy", busy, 0);

    flush();
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    check("midframe.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe.busy_rst", busy, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midframe.no_write", wa_q.size(), 0);
    check("midframe.no_reply", tx_q.size(), 0);

    fr = '{8'h47, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(fr, 1, 1'b1, "cmd_g2");
    send_byte(8'h00, 1'b1);
    repeat (12) @(negedge clk);
    check("midreply.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midreply.txd", txd, 1);
    check("midreply.core_rst", core_rst, 1);
    check("midreply.busy", busy, 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    flush();
    exp_core = 1'b1;

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 9);
      fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      if (kind == 0) begin
        fr[0] = 8'h52; run_txn(fr, 1, 1'b1, "rand_r");
      end else if (kind == 1) begin
        fr[0] = 8'h47; run_txn(fr, 1, 1'b1, "rand_g");
      end else if (kind == 2) begin
        ub = 8'($urandom_range(0, 255));
        if (ub == 8'h57 || ub == 8'h52 || ub == 8'h47) ub = 8'hA5;
        fr[0] = ub; run_txn(fr, 1, 1'b1, "rand_unknown");
      end else begin
        ah = 8'($urandom_range(0, 7));
        dh = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 5) == 0) ah = ah | 8'($urandom_range(1, 31) << 3);
        if ($urandom_range(0, 5) == 0) dh = dh | 8'($urandom_range(1, 3) << 6);
        set_w(fr, ah, 8'($urandom_range(0, 255)), dh, 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        run_txn(fr, 6, 1'b1, "rand_w");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
